cpeta_share_arbiter: RTL and testbench
======================================

// Module: cpeta_share_arbiter
// PURPOSE
//  Shares one adder datapath (CPETA approximate adder plus a full-width exact RCA) between two requesters.
//  Arbitration is round-robin. Each request carries an operand pair and a mode bit (approx/exact).
//  The result is registered and returned over a valid/ready response channel tagged with the requester id.
//  Per-requester saturating counters of completed operations are provided for profiling.
// PARAMETERS
//  N     16  operand/sum width
//  K      6  CPETA exact-upper-segment width (RCA over [N-1:N-K]); 4 <= K <= N-4
//  CNT_W 16  width of per-requester completion counters
// PORTS
//  clk         in   1    clock, all state on rising edge
//  rst_n       in   1    synchronous reset, active-low
//  req_valid   in   2    request valid, bit r = requester r
//  req_ready   out  2    request accepted this cycle (one-hot or zero)
//  req_a       in   2*N  operand A, slice [r*N +: N]
//  req_b       in   2*N  operand B, slice [r*N +: N]
//  req_exact   in   2    1 = exact sum mod 2^N, 0 = CPETA approximate sum
//  rsp_valid   out  1    response holding valid result
//  rsp_ready   in   1    downstream accepts response
//  rsp_id      out  1    requester that issued the result
//  rsp_sum     out  N    result
//  rsp_exact   out  1    mode used for this result
//  cnt0, cnt1  out  CNT_W completed-response counters, saturating at all-ones
// BEHAVIOUR
//  Reset (rst_n=0 at edge): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_exact=0, cnt0=cnt1=0, rr pointer=0 (req0 favoured).
//  Reset overrides everything. An in-flight response is dropped and is not counted.
//  Slot free := !rsp_valid || rsp_ready. req_ready is combinational and asserted only when the slot is free.
//  Arbitration (when slot free): one valid requester -> grant it. Both valid -> grant pointer's requester.
//  Pointer update: after any grant, pointer <= ~granted id. No grant -> pointer unchanged.
//  Handshake: request transfers on req_valid[r] && req_ready[r].
//    The requester holds a, b and exact stable until transfer.
//  Latency: 1 cycle. The sum is computed combinationally from the granted operands and registered at the transfer edge.
//    rsp_valid rises on the next cycle.
//  Throughput: 1 op/cycle while rsp_ready=1. Both requesters valid continuously -> strictly alternating grants.
//  Back-pressure: rsp_valid && !rsp_ready -> rsp_* held stable, req_ready=0.
//  Same-cycle drain and refill: rsp_ready=1 with a new grant -> the old response retires and the new one loads at the same edge, rsp_valid stays 1.
//  Drain without refill: no grant -> rsp_valid <= 0.
//  Counters: cnt[rsp_id] increments on rsp_valid && rsp_ready. It holds at 2^CNT_W-1 (no wrap).
//  Arithmetic, exact mode: (a+b) mod 2^N, carry-out discarded.
//  Arithmetic, approx mode (CPETA): c = a[N-K-1]&b[N-K-1].
//    sum[N-1:N-K] = a[N-1:N-K]+b[N-1:N-K]+c, truncated.
//    sum[N-K-1] = a^b at that bit.
//    sum[N-K-2] = a|b at that bit.
//    Bits N-K-3..0: sum[i] = a[i] | b[i] | g, where g = OR of a[j]&b[j] over j = i+1 .. N-K-2.
// STRUCTURE
//  Shared package cpeta_pkg: N_DEF, K_DEF, CNT_W_DEF; function cpeta_approx_sum(a,b) implementing the approx rule above (used by RTL and bench model).
//  One sub-module: rr_arbiter2 (inputs clk, rst_n, req[1:0], en). Outputs: gnt[1:0] one-hot, pointer state internal.
//  Adder datapath: a single mux-selected instance of the approx function plus exact '+'. Both modes share one operand mux.
// TESTING
//  1 Reset: hold rst_n=0 with req_valid=2'b11 -> req_ready=0 path irrelevant; after release rsp_valid=0, cnt0=cnt1=0, first contested grant to req0.
//  2 Modes, N=16 K=6, a=16'h00FF b=16'h0001: exact -> rsp_sum=16'h0100. Approx -> rsp_sum=16'h00FF (no carry into bit 8, bits 7..0 = a|b).
//  3 Contention: both valid 6 cycles, rsp_ready=1 -> grants 0,1,0,1,0,1. rsp_id follows 1 cycle later. Each counter = 3.
//  4 Back-pressure: rsp_ready=0 for 4 cycles with a pending response -> rsp_sum/rsp_id stable, req_ready=0. Release -> 1 retire and 1 new load at the same edge.
//  5 Reset mid-operation: rsp_valid=1, rst_n=0 one cycle -> rsp_valid=0 and counters 0. The dropped response is not counted.
//  6 Saturation with CNT_W=4: 20 req0 completions -> cnt0=4'hF and held. cnt1=0.

Source files
------------

// File: rtl/cpeta_pkg.sv
// cpeta_pkg: shared widths and the CPETA approximate-sum rule. Rev 1.0
`default_nettype none

package cpeta_pkg;

  localparam int N_DEF     = 16;
  localparam int K_DEF     = 6;
  localparam int CNT_W_DEF = 16;
  localparam int MAX_W     = 64;

  // n-bit CPETA sum with k-bit exact upper segment; operands zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] cpeta_approx_sum(input logic [MAX_W-1:0] a,
                                                        input logic [MAX_W-1:0] b,
                                                        input int n,
                                                        input int k);
    logic [MAX_W-1:0] one;
    logic [MAX_W-1:0] mk;
    logic [MAX_W-1:0] up;
    logic [MAX_W-1:0] p;
    logic [MAX_W-1:0] g;
    logic [MAX_W-1:0] s;
    logic             cbit;
    int               m;
    m    = n - k;
    one  = {{(MAX_W-1){1'b0}}, 1'b1};
    mk   = (one << k) - one;
    cbit = |(((a & b) >> (m - 1)) & one);
    up   = (((a >> m) & mk) + ((b >> m) & mk) + (cbit ? one : '0)) & mk;
    s    = up << m;
    s    = s | ((((a ^ b) >> (m - 1)) & one) << (m - 1));
    s    = s | ((((a | b) >> (m - 2)) & one) << (m - 2));
    // Smear generate bits downward so g[i] = OR of a&b over i+1 .. m-2.
    p = a & b & ((one << (m - 1)) - one);
    for (int sh = 1; sh < MAX_W; sh = sh * 2) begin
      p = p | (p >> sh);
    end
    g = p >> 1;
    s = s | ((a | b | g) & ((one << (m - 2)) - one));
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter, pointer flips to the loser after a grant. Rev 1.0
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
      else      gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    ptr <= 1'b0;
    else if (|gnt) ptr <= ~gnt[1];
  end

endmodule

`default_nettype wire

// File: rtl/cpeta_share_arbiter.sv
// cpeta_share_arbiter: two requesters share one CPETA/exact adder, registered response. Rev 1.0
`default_nettype none

module cpeta_share_arbiter
  import cpeta_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int K     = K_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2*N-1:0]   req_a,
  input  logic [2*N-1:0]   req_b,
  input  logic [1:0]       req_exact,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [N-1:0]     rsp_sum,
  output logic             rsp_exact,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic             slot_free;
  logic [1:0]       gnt;
  logic             gid;
  logic [N-1:0]     a_sel;
  logic [N-1:0]     b_sel;
  logic             exact_sel;
  logic [N-1:0]     approx_sum;
  logic [N-1:0]     sum_next;
  logic [CNT_W-1:0] cnt_q [2];

  assign slot_free = !rsp_valid || rsp_ready;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (slot_free),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign gid       = gnt[1];

  // One operand mux feeds both adders; only the granted slice matters.
  assign a_sel     = gid ? req_a[N +: N] : req_a[0 +: N];
  assign b_sel     = gid ? req_b[N +: N] : req_b[0 +: N];
  assign exact_sel = gid ? req_exact[1]  : req_exact[0];

  assign approx_sum = N'(cpeta_approx_sum(MAX_W'(a_sel), MAX_W'(b_sel), N, K));
  assign sum_next   = exact_sel ? (a_sel + b_sel) : approx_sum;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_exact <= 1'b0;
    end else if (|gnt) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gid;
      rsp_sum   <= sum_next;
      rsp_exact <= exact_sel;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  generate
    for (genvar r = 0; r < 2; r++) begin : g_cnt
      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt_q[r] <= '0;
        else if (rsp_valid && rsp_ready && (rsp_id == 1'(r)) && !(&cnt_q[r]))
          cnt_q[r] <= cnt_q[r] + 1'b1;
      end
    end
  endgenerate

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];

endmodule

`default_nettype wire

// File: tb/tb_cpeta_share_arbiter.sv
// tb_cpeta_share_arbiter: directed and random checks against a cycle-level reference model. Rev 1.0
`default_nettype none

module tb_cpeta_share_arbiter;

  localparam int N = 16;
  localparam int K = 6;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_b;
  logic [1:0]    req_exact;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_id;
  logic [N-1:0]  rsp_sum;
  logic          rsp_exact;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  int total = 0;
  int bad   = 0;

  cpeta_share_arbiter #(.N(N), .K(K), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_exact (req_exact),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_exact (rsp_exact),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit-by-bit reading of the approximate rule for N=16, K=6.
  function automatic logic [15:0] ref_approx(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s, ab, o, g;
    logic c;
    ab = a & b;
    o  = a | b;
    c  = a[9] & b[9];
    s  = '0;
    s[15:10] = a[15:10] + b[15:10] + {5'b0, c};
    s[9] = a[9] ^ b[9];
    s[8] = a[8] | b[8];
    for (int i = 7; i >= 0; i--) begin
      g = '0;
      for (int j = i + 1; j <= 8; j++) g = g | ((ab >> j) & 16'd1);
      s = s | ((((o >> i) & 16'd1) | g) << i);
    end
    return s;
  endfunction

  // Reference model state
  logic          started = 1'b0;
  logic          m_valid;
  logic          m_id;
  logic [N-1:0]  m_sum;
  logic          m_exact;
  logic          m_fav;
  logic [CW-1:0] m_cnt [2];

  function automatic logic [1:0] model_grant();
    if (m_valid && !rsp_ready) return 2'b00;
    if (req_valid == 2'b11)    return m_fav ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  function automatic logic gid_of(input logic [1:0] g);
    return g[1];
  endfunction

  function automatic logic [N-1:0] model_sum(input logic r);
    logic [N-1:0] a, b;
    a = req_a[r*N +: N];
    b = req_b[r*N +: N];
    return req_exact[r] ? N'(a + b) : ref_approx(a, b);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_id     <= 1'b0;
      m_sum    <= '0;
      m_exact  <= 1'b0;
      m_fav    <= 1'b0;
      m_cnt[0] <= '0;
      m_cnt[1] <= '0;
    end else if (started) begin
      if (m_valid && rsp_ready) m_cnt[m_id] <= sat_inc(m_cnt[m_id]);
      if (model_grant() != 2'b00) begin
        m_valid <= 1'b1;
        m_id    <= gid_of(model_grant());
        m_sum   <= model_sum(gid_of(model_grant()));
        m_exact <= req_exact[gid_of(model_grant())];
        m_fav   <= ~gid_of(model_grant());
      end else if (rsp_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Compare process: the model is only trusted once a reset edge has been seen.
  logic seen_rst = 1'b0;
  always @(posedge clk) if (!rst_n) seen_rst <= 1'b1;

  always @(negedge clk) begin
    if (started && seen_rst) begin
      if (rst_n) chk("req_ready", 32'(req_ready), 32'(model_grant()));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
      if (m_valid) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_sum", 32'(rsp_sum), 32'(m_sum));
        chk("rsp_exact", 32'(rsp_exact), 32'(m_exact));
      end
      chk("cnt0", 32'(cnt0), 32'(m_cnt[0]));
      chk("cnt1", 32'(cnt1), 32'(m_cnt[1]));
    end
  end

  logic [1:0] acc;
  logic [1:0] last_ready;

  task automatic cycle();
    @(negedge clk);
    last_ready = req_ready;
    acc = rst_n ? (req_valid & req_ready) : 2'b00;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int r, input logic [15:0] a, input logic [15:0] b, input logic ex);
    req_a[r*N +: N] = a;
    req_b[r*N +: N] = b;
    req_exact[r]    = ex;
  endtask

  logic [1:0]  exp_gnt [6];
  logic [CW-1:0] c0;

  initial begin
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    acc = 2'b00;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    put(0, 16'h1111, 16'h2222, 1'b1);
    put(1, 16'h0F00, 16'h0100, 1'b0);

    // Model pins
    chk("ref_approx_00ff", 32'(ref_approx(16'h00FF, 16'h0001)), 32'h00FF);
    chk("ref_approx_0300", 32'(ref_approx(16'h0300, 16'h0100)), 32'h03FF);
    chk("ref_approx_0200", 32'(ref_approx(16'h0200, 16'h0200)), 32'h0400);

    // Reset with both requesting, then the first contested grant goes to req0
    repeat (3) cycle();
    rst_n = 1'b1;
    #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    chk("rst_first_grant", 32'(req_ready), 32'b01);

    // Contention: strictly alternating grants
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("contend_grant", 32'(last_ready), 32'(exp_gnt[i]));
    end
    req_valid = 2'b00;
    cycle();
    #3;
    chk("contend_cnt0", 32'(cnt0), 32'd3);
    chk("contend_cnt1", 32'(cnt1), 32'd3);

    // Modes
    req_valid = 2'b01;
    put(0, 16'h00FF, 16'h0001, 1'b1);
    cycle(); req_valid = 2'b00; #3;
    chk("mode_exact_sum", 32'(rsp_sum), 32'h0100);
    chk("mode_exact_flag", 32'(rsp_exact), 32'd1);
    req_valid = 2'b01;
    put(0, 16'h00FF, 16'h0001, 1'b0);
    cycle(); req_valid = 2'b00; #3;
    chk("mode_approx_sum", 32'(rsp_sum), 32'h00FF);
    chk("mode_approx_flag", 32'(rsp_exact), 32'd0);
    req_valid = 2'b01;
    put(0, 16'h0300, 16'h0100, 1'b0);
    cycle(); req_valid = 2'b00; #3;
    chk("mode_approx_gen", 32'(rsp_sum), 32'h03FF);
    cycle();

    // Back-pressure
    rsp_ready = 1'b0;
    req_valid = 2'b01;
    put(0, 16'h1234, 16'h1111, 1'b1);
    cycle();
    req_valid = 2'b10;
    put(1, 16'h0F0F, 16'h0101, 1'b0);
    #3;
    chk("bp_loaded_sum", 32'(rsp_sum), 32'h2345);
    for (int i = 0; i < 4; i++) begin
      cycle(); #3;
      chk("bp_hold_sum", 32'(rsp_sum), 32'h2345);
      chk("bp_hold_id", 32'(rsp_id), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    c0 = cnt0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'b10);
    cycle();
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    #3;
    chk("bp_refill_valid", 32'(rsp_valid), 32'd1);
    chk("bp_refill_id", 32'(rsp_id), 32'd1);
    chk("bp_refill_sum", 32'(rsp_sum), 32'h0FFF);
    chk("bp_retire_cnt0", 32'(cnt0), 32'(CW'(c0 + 1'b1)));

    // Reset while a response is pending
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    cycle();
    rst_n = 1'b1;
    #3;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cnt0", 32'(cnt0), 32'd0);
    chk("midrst_cnt1", 32'(cnt1), 32'd0);
    cycle(); #3;
    chk("midrst_dropped", 32'(cnt1), 32'd0);

    // Saturation
    req_valid = 2'b01;
    put(0, 16'($urandom), 16'($urandom), 1'($urandom));
    repeat (20) cycle();
    req_valid = 2'b00;
    cycle(); #3;
    chk("sat_cnt0", 32'(cnt0), 32'hF);
    chk("sat_cnt1", 32'(cnt1), 32'd0);
    repeat (3) cycle();
    chk("sat_hold_cnt0", 32'(cnt0), 32'hF);

    // Random traffic; pending requests keep their operands until accepted
    for (int t = 0; t < 3000; t++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < 2; r++) begin
        if (!(req_valid[r] && !acc[r])) begin
          req_valid[r] = ($urandom_range(0, 2) != 0);
          if ($urandom_range(0, 7) == 0) put(r, 16'hFFFF, 16'($urandom), 1'($urandom));
          else                           put(r, 16'($urandom), 16'($urandom), 1'($urandom));
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
